// File: rtl/conv_window_ctrl_pkg.sv
// Shared constants and FSM encoding for the convolution window controller.
package conv_window_ctrl_pkg;

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_K      = 5;
  localparam int DEF_NUM_CH = 6;
  localparam int DEF_OUT_W  = DEF_IMG_W - DEF_K + 1;
  localparam int DEF_OUT_H  = DEF_IMG_H - DEF_K + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_window_ctrl_tag_delay.sv
// Fixed-latency tag pipeline that tracks results through the multiply/adder
// tree. The MSB of each entry is its valid bit; flush empties every stage.
module tag_delay_line
  import conv_window_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             pending
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per cycle; never stalls because the result sink always accepts.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

  // Valid tags that will still be in flight after this cycle (output stage excluded).
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage[i][WIDTH-1];
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences window origins (col, row, channel) to the window-fetch unit and
// tags each issued window so results emerge LAT cycles later with their
// channel and flat output address.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | presenting window origins, one issue per win_ready handshake
// ST_DRAIN | all origins issued, waiting for the tag pipeline to empty
// ST_DONE  | one-cycle done pulse, then back to idle
module conv_window_ctrl
  import conv_window_ctrl_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LAT    = 3
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic                                         abort,
  input  logic                                         win_ready,
  output logic                                         win_valid,
  output logic [$clog2(IMG_H)-1:0]                     win_row,
  output logic [$clog2(IMG_W)-1:0]                     win_col,
  output logic [$clog2(NUM_CH)-1:0]                    ch_sel,
  output logic                                         res_valid,
  output logic [$clog2(NUM_CH)-1:0]                    res_ch,
  output logic [$clog2((IMG_W-K+1)*(IMG_H-K+1))-1:0]   res_addr,
  output logic                                         busy,
  output logic                                         done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int RW    = $clog2(IMG_H);
  localparam int CLW   = $clog2(IMG_W);
  localparam int CW    = $clog2(NUM_CH);
  localparam int AW    = $clog2(OUT_W * OUT_H);
  localparam int TW    = 1 + CW + AW;

  localparam logic [CLW-1:0] COL_LAST = CLW'(OUT_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(OUT_H - 1);
  localparam logic [CW-1:0]  CH_LAST  = CW'(NUM_CH - 1);

  state_t state, state_nxt;

  logic [CLW-1:0] col;
  logic [RW-1:0]  row;
  logic [CW-1:0]  ch;
  logic [AW-1:0]  addr;

  logic          issue;
  logic          last_issue;
  logic          pipe_pending;
  logic [TW-1:0] tag_in;
  logic [TW-1:0] tag_out;

  // A handshake in the abort cycle is discarded: the frame is being cancelled.
  assign issue      = (state == ST_RUN) && win_ready && !abort;
  assign last_issue = issue && (col == COL_LAST) && (row == ROW_LAST) && (ch == CH_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything including start.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_RUN;
        ST_RUN:   if (last_issue) state_nxt = ST_DRAIN;
        ST_DRAIN: if (!pipe_pending) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Origin counters: col fastest, then row, then channel. The flat address
  // tracks row*OUT_W+col incrementally and restarts at each channel change.
  always_ff @(posedge clk) begin
    if (!rst_n || abort || state != ST_RUN) begin
      col  <= '0;
      row  <= '0;
      ch   <= '0;
      addr <= '0;
    end else if (issue) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row  <= '0;
          addr <= '0;
          ch   <= (ch == CH_LAST) ? '0 : ch + 1'b1;
        end else begin
          row  <= row + 1'b1;
          addr <= addr + 1'b1;
        end
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

  assign tag_in = issue ? {1'b1, ch, addr} : '0;

  tag_delay_line #(
    .DEPTH (LAT),
    .WIDTH (TW)
  ) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .din     (tag_in),
    .dout    (tag_out),
    .pending (pipe_pending)
  );

  assign win_valid = (state == ST_RUN);
  assign win_row   = row;
  assign win_col   = col;
  assign ch_sel    = ch;
  assign res_valid = tag_out[TW-1];
  assign res_ch    = tag_out[AW +: CW];
  assign res_addr  = tag_out[AW-1:0];
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized bench for conv_window_ctrl with a frame-level reference model,
// plus a small LAT=1 instance for the reset-during-drain case.
module tb_conv_window_ctrl;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int K      = 5;
  localparam int NUM_CH = 6;
  localparam int LAT    = 3;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int OUT_H  = IMG_H - K + 1;
  localparam int OUT_N  = OUT_W * OUT_H;
  localparam int TOT    = OUT_N * NUM_CH;

  logic       clk;
  logic       rst_n, start, abort, win_ready;
  logic       win_valid, res_valid, busy, done;
  logic [4:0] win_row, win_col;
  logic [2:0] ch_sel, res_ch;
  logic [9:0] res_addr;

  logic       rst1_n, start1, abort1, win_ready1;
  logic       win_valid1, res_valid1, busy1, done1;
  logic [2:0] win_row1, win_col1;
  logic [0:0] ch_sel1, res_ch1;
  logic [3:0] res_addr1;

  conv_window_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_CH(NUM_CH), .LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_ready(win_ready),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .ch_sel(ch_sel),
    .res_valid(res_valid), .res_ch(res_ch), .res_addr(res_addr), .busy(busy), .done(done)
  );

  conv_window_ctrl #(
    .IMG_W(8), .IMG_H(8), .K(5), .NUM_CH(2), .LAT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .abort(abort1), .win_ready(win_ready1),
    .win_valid(win_valid1), .win_row(win_row1), .win_col(win_col1), .ch_sel(ch_sel1),
    .res_valid(res_valid1), .res_ch(res_ch1), .res_addr(res_addr1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int ch; int addr; } res_t;
  res_t q[$];
  int   cyc      = 0;
  bit   running  = 0;
  bit   drain    = 0;
  int   idx      = 0;
  int   done_cyc = -1;
  int   res_cnt  = 0;
  bit   chk_en   = 0;
  bit   rnd_ready = 0;

  // Frame bookkeeping from the sampled inputs at each rising edge.
  always @(posedge clk) begin
    bit   idle;
    res_t r;
    if (!rst_n || abort) begin
      running  = 0;
      drain    = 0;
      done_cyc = -1;
      q.delete();
    end else begin
      idle = !running && !drain;
      if (idle) begin
        if (start) begin
          running = 1;
          idx     = 0;
          res_cnt = 0;
        end
      end else if (running && win_ready) begin
        r.due  = cyc + LAT;
        r.ch   = idx / OUT_N;
        r.addr = idx % OUT_N;
        q.push_back(r);
        idx++;
        if (idx == TOT) begin
          running  = 0;
          drain    = 1;
          done_cyc = cyc + LAT + 1;
        end
      end else if (drain && cyc == done_cyc) begin
        drain = 0;
      end
    end
    cyc = cyc + 1;
  end

  bit have_prev = 0;
  int prev_ch, prev_row, prev_col;
  int prev_res_ch = -1;

  // Compare DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    bit exp_rv;
    if (chk_en) begin
      check("win_valid", win_valid, running);
      if (running) begin
        check("ch_sel",  ch_sel,  idx / OUT_N);
        check("win_row", win_row, (idx % OUT_N) / OUT_W);
        check("win_col", win_col, idx % OUT_W);
      end
      check("busy", busy, running || (drain && cyc < done_cyc));
      check("done", done, drain && cyc == done_cyc);
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      exp_rv = (q.size() > 0) && (q[0].due == cyc);
      check("res_valid", res_valid, exp_rv);
      if (exp_rv) begin
        check("res_ch",   res_ch,   q[0].ch);
        check("res_addr", res_addr, q[0].addr);
        void'(q.pop_front());
        res_cnt++;
      end
      if (drain && cyc == done_cyc) check("frame_res_count", res_cnt, TOT);

      if (win_valid && win_ready) begin
        if (have_prev && prev_ch == 0 && prev_row == 0 && prev_col == 23) begin
          check("wrap_col_row", win_row, 1);
          check("wrap_col_col", win_col, 0);
        end
        if (have_prev && prev_ch == 0 && prev_row == 23 && prev_col == 23) begin
          check("wrap_row_ch",  ch_sel,  1);
          check("wrap_row_row", win_row, 0);
          check("wrap_row_col", win_col, 0);
        end
        have_prev = 1;
        prev_ch = ch_sel; prev_row = win_row; prev_col = win_col;
      end else if (!win_valid) begin
        have_prev = 0;
      end
      if (res_valid) begin
        if (prev_res_ch == 0 && res_ch == 1) check("res_addr_restart", res_addr, 0);
        prev_res_ch = res_ch;
      end
    end
  end

  // win_ready: tied high or 50% random, changed just after each edge.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic run_frame(input bit rnd);
    int  n_iss = 0, n_res = 0;
    int  fi = -1, li = -1, fr = -1, lr = -1, fr_ch = -1, fr_addr = -1;
    int  lr_ch = -1, lr_addr = -1, dc = -1;
    bit  got_done = 0;
    rnd_ready = rnd;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      if (win_valid && win_ready) begin
        if (fi < 0) fi = cyc;
        li = cyc;
        n_iss++;
      end
      if (res_valid) begin
        if (fr < 0) begin fr = cyc; fr_ch = res_ch; fr_addr = res_addr; end
        lr = cyc; lr_ch = res_ch; lr_addr = res_addr;
        n_res++;
      end
      if (done) begin got_done = 1; dc = cyc; break; end
      start = (rnd && win_valid && $urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    rnd_ready = 0;
    check("frame_done_seen", got_done, 1);
    check("frame_issues", n_iss, 3456);
    check("frame_results", n_res, 3456);
    check("first_res_latency", fr - fi, 3);
    check("first_res_ch", fr_ch, 0);
    check("first_res_addr", fr_addr, 0);
    check("last_res_ch", lr_ch, 5);
    check("last_res_addr", lr_addr, 575);
    check("done_after_last_res", dc - lr, 1);
    if (!rnd) check("issues_consecutive", li - fi, 3455);
  endtask

  initial begin
    int  n;
    int  fi1, fr1;
    bit  found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    rst1_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; win_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_win_valid", win_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_addr", res_addr, 0);
    rst_n = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    run_frame(0);
    repeat (3) @(negedge clk);
    run_frame(1);
    repeat (3) @(negedge clk);

    // Abort two cycles after an issue: the in-flight result must never appear.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (120) @(negedge clk);
    check("abort_pre_issue", win_valid && win_ready, 1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_win_valid", win_valid, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid || done) n++;
      @(negedge clk);
    end
    check("abort_quiet", n, 0);
    run_frame(0);
    repeat (2) @(negedge clk);

    // start together with abort in IDLE must be ignored.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_win_valid", win_valid, 0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_win_valid", win_valid, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_win_col", win_col, 0);
    check("midrst_res_addr", res_addr, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // LAT=1 instance: reset while draining.
    rst1_n = 1'b1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    fi1 = -1; fr1 = -1; found = 0;
    for (int i = 0; i < 200; i++) begin
      if (win_valid1 && win_ready1 && fi1 < 0) fi1 = cyc;
      if (res_valid1 && fr1 < 0) fr1 = cyc;
      if (busy1 && !win_valid1) begin
        found = 1;
        check("lat1_drain_res_valid", res_valid1, 1);
        check("lat1_drain_res_ch", res_ch1, 1);
        check("lat1_drain_res_addr", res_addr1, 15);
        rst1_n = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("lat1_drain_reached", found, 1);
    check("lat1_first_res_latency", fr1 - fi1, 1);
    @(negedge clk);
    check("lat1_rst_win_valid", win_valid1, 0);
    check("lat1_rst_res_valid", res_valid1, 0);
    check("lat1_rst_busy", busy1, 0);
    check("lat1_rst_done", done1, 0);
    check("lat1_rst_win_row", win_row1, 0);
    check("lat1_rst_win_col", win_col1, 0);
    check("lat1_rst_ch_sel", ch_sel1, 0);
    check("lat1_rst_res_ch", res_ch1, 0);
    check("lat1_rst_res_addr", res_addr1, 0);
    rst1_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1 || res_valid1 || busy1) n++;
    end
    check("lat1_quiet_after_rst", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
